// File: rtl/aes_encrypt_param.sv
// Iterative AES block encryptor for 128/192/256-bit keys.
// One round per cycle; the expanded key schedule is cached across blocks.

module aes_encrypt_param #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                new_key,
    input  logic [127:0]        in,
    input  logic [KEY_BITS-1:0] key,
    output logic                busy,
    output logic                finish,
    output logic [127:0]        out
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [5:0] LAST_W = 6'(NW - 1);
    localparam logic [3:0] LAST_R = 4'(NR);
    localparam logic [2:0] LAST_K = 3'(NK - 1);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
            $error("aes_encrypt_param: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    // S-box table, byte 0x00 in the top bits
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {IDLE, EXPAND, ROUND} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                go_expand;
    logic                sched_valid;
    logic [127:0]        data_reg;
    logic [NW-1:0][31:0] w;
    logic [NK-1:0][31:0] key_words;
    logic [5:0]          i;
    logic [2:0]          kmod;
    logic [7:0]          rcon;
    logic [3:0]          r;

    // ---------------- key path ----------------
    logic [31:0] prev_w;
    logic [31:0] far_w;
    logic [31:0] sub_in;
    logic [31:0] sub_w;
    logic [31:0] temp_w;
    logic [31:0] new_w;

    // key word 0 is the most significant word of the key
    for (genvar g = 0; g < NK; g++) begin : g_key
        assign key_words[g] = key[KEY_BITS-1-32*g -: 32];
    end

    assign prev_w = w[i - 6'd1];
    assign far_w  = w[i - NK_W];
    assign sub_in = (kmod == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar g = 0; g < 4; g++) begin : g_subword
        assign sub_w[8*g +: 8] = sbox(sub_in[8*g +: 8]);
    end

    // select the schedule transform for the current word position
    always_comb begin
        temp_w = prev_w;
        if (kmod == 3'd0) begin
            temp_w = sub_w ^ {rcon, 24'h000000};
        end else if (NK == 8 && kmod == 3'd4) begin
            temp_w = sub_w;
        end
    end

    assign new_w = far_w ^ temp_w;

    // ---------------- state path ----------------
    logic [127:0] sub_s;
    logic [127:0] sr;
    logic [127:0] mc;
    logic [127:0] rk;
    logic [127:0] round_out;

    for (genvar g = 0; g < 16; g++) begin : g_subbytes
        assign sub_s[8*g +: 8] = sbox(data_reg[8*g +: 8]);
    end

    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        for (genvar gr = 0; gr < 4; gr++) begin : g_row
            assign sr[127-8*(4*gc+gr) -: 8] =
                sub_s[127-8*(4*((gc+gr)%4)+gr) -: 8];
        end
    end

    for (genvar gc = 0; gc < 4; gc++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr[127-32*gc -: 8];
        assign a1 = sr[119-32*gc -: 8];
        assign a2 = sr[111-32*gc -: 8];
        assign a3 = sr[103-32*gc -: 8];
        assign mc[127-32*gc -: 32] = {
            xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)
        };
    end

    assign rk = {w[{r, 2'b00}], w[{r, 2'b01}], w[{r, 2'b10}], w[{r, 2'b11}]};

    // pick the round flavour: initial whitening, full round or final round
    always_comb begin
        round_out = mc ^ rk;
        if (r == 4'd0) begin
            round_out = data_reg ^ rk;
        end else if (r == LAST_R) begin
            round_out = sr ^ rk;
        end
    end

    assign busy = (state != IDLE);

    // ---------------- control ----------------
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic; expansion is forced when no valid schedule is cached
    always_comb begin
        state_nxt = state;
        go_expand = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (new_key || !sched_valid) begin
                        state_nxt = EXPAND;
                        go_expand = 1'b1;
                    end else begin
                        state_nxt = ROUND;
                    end
                end
            end
            EXPAND: begin
                if (i == LAST_W) begin
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                if (r == LAST_R) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // counters, data register, output and schedule-valid flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            finish      <= 1'b0;
            out         <= '0;
            data_reg    <= '0;
            sched_valid <= 1'b0;
            i           <= '0;
            kmod        <= '0;
            rcon        <= 8'h01;
            r           <= '0;
        end else begin
            finish <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        data_reg <= in;
                        r        <= '0;
                        if (go_expand) begin
                            sched_valid <= 1'b0;
                            i           <= NK_W;
                            kmod        <= '0;
                            rcon        <= 8'h01;
                        end
                    end
                end
                EXPAND: begin
                    i    <= i + 6'd1;
                    kmod <= (kmod == LAST_K) ? 3'd0 : kmod + 3'd1;
                    if (kmod == 3'd0) begin
                        rcon <= xt(rcon);
                    end
                    if (i == LAST_W) begin
                        sched_valid <= 1'b1;
                        r           <= '0;
                    end
                end
                ROUND: begin
                    data_reg <= round_out;
                    r        <= r + 4'd1;
                    if (r == LAST_R) begin
                        out    <= round_out;
                        finish <= 1'b1;
                        r      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // round-key buffer; contents need no reset
    always_ff @(posedge clk) begin
        if (go_expand) begin
            w[NK-1:0] <= key_words;
        end else if (state == EXPAND) begin
            w[i] <= new_w;
        end
    end

endmodule

// File: tb/tb_aes_encrypt_param.sv
// Directed bench for aes_encrypt_param at 128/192/256-bit keys.
// Uses FIPS-197 and SP800-38A known-answer vectors.

module tb_aes_encrypt_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic         st128 = 1'b0, nk128 = 1'b0;
    logic [127:0] in128 = '0;
    logic [127:0] key128 = '0;
    logic         busy128, fin128;
    logic [127:0] out128;

    logic         st192 = 1'b0, nk192 = 1'b0;
    logic [127:0] in192 = '0;
    logic [191:0] key192 = '0;
    logic         busy192, fin192;
    logic [127:0] out192;

    logic         st256 = 1'b0, nk256 = 1'b0;
    logic [127:0] in256 = '0;
    logic [255:0] key256 = '0;
    logic         busy256, fin256;
    logic [127:0] out256;

    aes_encrypt_param #(.KEY_BITS(128)) d128 (
        .clk(clk), .rst(rst_n), .start(st128), .new_key(nk128),
        .in(in128), .key(key128), .busy(busy128), .finish(fin128),
        .out(out128)
    );

    aes_encrypt_param #(.KEY_BITS(192)) d192 (
        .clk(clk), .rst(rst_n), .start(st192), .new_key(nk192),
        .in(in192), .key(key192), .busy(busy192), .finish(fin192),
        .out(out192)
    );

    aes_encrypt_param #(.KEY_BITS(256)) d256 (
        .clk(clk), .rst(rst_n), .start(st256), .new_key(nk256),
        .in(in256), .key(key256), .busy(busy256), .finish(fin256),
        .out(out256)
    );

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    logic         fin_s, busy_s;
    logic [127:0] out_s;

    always_comb begin
        fin_s  = fin128;
        busy_s = busy128;
        out_s  = out128;
        if (sel == 1) begin
            fin_s  = fin192;
            busy_s = busy192;
            out_s  = out192;
        end else if (sel == 2) begin
            fin_s  = fin256;
            busy_s = busy256;
            out_s  = out256;
        end
    end

    localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KF   = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K192 =
        256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KN   = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CF   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // called at a negedge; start is held across exactly one rising edge
    task automatic launch(input int s, input logic nkv,
                          input logic [127:0] pt, input logic [255:0] kv);
        sel = s;
        case (s)
            0: begin st128 = 1'b1; nk128 = nkv; in128 = pt; key128 = kv[127:0]; end
            1: begin st192 = 1'b1; nk192 = nkv; in192 = pt; key192 = kv[191:0]; end
            default: begin st256 = 1'b1; nk256 = nkv; in256 = pt; key256 = kv; end
        endcase
        @(negedge clk);
        st128 = 1'b0;
        st192 = 1'b0;
        st256 = 1'b0;
    endtask

    // cycles from the start edge to the finish pulse; -1 if it never came
    task automatic wait_finish(input int bound, output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (fin_s !== 1'b1 && lat < bound) begin
            if (busy_s !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (fin_s !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total += 9;
        if (busy128 !== 1'b0) begin bad++; $display("FAIL rst_busy128 got %b want 0", busy128); end
        if (fin128 !== 1'b0) begin bad++; $display("FAIL rst_fin128 got %b want 0", fin128); end
        if (out128 !== '0) begin bad++; $display("FAIL rst_out128 got %h want 0", out128); end
        if (busy192 !== 1'b0) begin bad++; $display("FAIL rst_busy192 got %b want 0", busy192); end
        if (fin192 !== 1'b0) begin bad++; $display("FAIL rst_fin192 got %b want 0", fin192); end
        if (out192 !== '0) begin bad++; $display("FAIL rst_out192 got %h want 0", out192); end
        if (busy256 !== 1'b0) begin bad++; $display("FAIL rst_busy256 got %b want 0", busy256); end
        if (fin256 !== 1'b0) begin bad++; $display("FAIL rst_fin256 got %b want 0", fin256); end
        if (out256 !== '0) begin bad++; $display("FAIL rst_out256 got %h want 0", out256); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips128();
        int lat;
        bit bok;
        launch(0, 1'b1, PT0, KF);
        wait_finish(200, lat, bok);
        total += 4;
        if (lat !== 51) begin bad++; $display("FAIL f128_latency got %0d want 51", lat); end
        if (bok !== 1'b1) begin bad++; $display("FAIL f128_busy got %b want 1", bok); end
        if (out128 !== CF) begin bad++; $display("FAIL f128_out got %h want %h", out128, CF); end
        @(negedge clk);
        if (fin128 !== 1'b0) begin bad++; $display("FAIL f128_pulse got %b want 0", fin128); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts [4] = '{
            128'h6bc1bee22e409f96e93d7e117393172a,
            128'hae2d8a571e03ac9c9eb76fac45af8e51,
            128'h30c81c46a35ce411e5fbc1191a0a52ef,
            128'hf69f2445df4f9b17ad2b417be66c3710};
        logic [127:0] cts [4] = '{
            128'h3ad77bb40d7a3660a89ecaf32466ef97,
            128'hf5d3d58503b9699de785895a96fdbaaf,
            128'h43b1cd7f598ece23881b00e3ed030688,
            128'h7b0c785e27e8ad3f8223207104725dd4};
        int lat;
        int want;
        bit bok;
        for (int b = 0; b < 4; b++) begin
            launch(0, (b == 0), pts[b], KN);
            wait_finish(200, lat, bok);
            want = (b == 0) ? 51 : 11;
            total += 2;
            if (lat !== want) begin bad++; $display("FAIL b2b_latency%0d got %0d want %0d", b, lat, want); end
            if (out128 !== cts[b]) begin bad++; $display("FAIL b2b_out%0d got %h want %h", b, out128, cts[b]); end
        end
        @(negedge clk);
        total += 2;
        if (fin128 !== 1'b0) begin bad++; $display("FAIL b2b_pulse got %b want 0", fin128); end
        if (busy128 !== 1'b0) begin bad++; $display("FAIL b2b_idle got %b want 0", busy128); end
    endtask

    task automatic test_reset_mid_expand();
        int lat;
        int fins;
        bit bok;
        bit idle_ok;
        launch(0, 1'b1, PT0, KF);
        repeat (10) @(negedge clk);
        total += 1;
        if (busy128 !== 1'b1) begin bad++; $display("FAIL mid_busy got %b want 1", busy128); end
        #2 rst_n = 1'b0;
        #1;
        total += 3;
        if (busy128 !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got %b want 0", busy128); end
        if (fin128 !== 1'b0) begin bad++; $display("FAIL mid_rst_fin got %b want 0", fin128); end
        if (out128 !== '0) begin bad++; $display("FAIL mid_rst_out got %h want 0", out128); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fins = 0;
        idle_ok = 1'b1;
        for (int m = 0; m < 60; m++) begin
            @(negedge clk);
            if (fin128 === 1'b1) fins++;
            if (busy128 !== 1'b0) idle_ok = 1'b0;
        end
        total += 2;
        if (fins !== 0) begin bad++; $display("FAIL mid_no_finish got %0d want 0", fins); end
        if (idle_ok !== 1'b1) begin bad++; $display("FAIL mid_idle got %b want 1", idle_ok); end
        launch(0, 1'b0, PT0, KF);
        wait_finish(200, lat, bok);
        total += 2;
        if (lat !== 51) begin bad++; $display("FAIL mid_reexpand_latency got %0d want 51", lat); end
        if (out128 !== CF) begin bad++; $display("FAIL mid_reexpand_out got %h want %h", out128, CF); end
    endtask

    task automatic test_rekey();
        int lat;
        bit bok;
        launch(0, 1'b0, PT0, KF);
        wait_finish(200, lat, bok);
        total += 2;
        if (lat !== 11) begin bad++; $display("FAIL rekey_cached_latency got %0d want 11", lat); end
        if (out128 !== CF) begin bad++; $display("FAIL rekey_cached_out got %h want %h", out128, CF); end
        launch(0, 1'b1, 128'h6bc1bee22e409f96e93d7e117393172a, KN);
        wait_finish(200, lat, bok);
        total += 2;
        if (lat !== 51) begin bad++; $display("FAIL rekey_latency got %0d want 51", lat); end
        if (out128 !== 128'h3ad77bb40d7a3660a89ecaf32466ef97) begin
            bad++;
            $display("FAIL rekey_out got %h want 3ad77bb40d7a3660a89ecaf32466ef97", out128);
        end
        @(negedge clk);
    endtask

    task automatic test_aes192();
        int lat;
        bit bok;
        launch(1, 1'b1, PT0, K192);
        wait_finish(200, lat, bok);
        total += 3;
        if (lat !== 59) begin bad++; $display("FAIL a192_latency got %0d want 59", lat); end
        if (bok !== 1'b1) begin bad++; $display("FAIL a192_busy got %b want 1", bok); end
        if (out192 !== 128'hdda97ca4864cdfe06eaf70a0ec0d7191) begin
            bad++;
            $display("FAIL a192_out got %h want dda97ca4864cdfe06eaf70a0ec0d7191", out192);
        end
        @(negedge clk);
    endtask

    task automatic test_aes256_ignore_start();
        int lat;
        int fins;
        logic [127:0] got;
        launch(2, 1'b1, PT0, K256);
        fins = 0;
        lat = -1;
        got = '0;
        for (int m = 0; m < 100; m++) begin
            if (m == 5) begin
                st256 = 1'b1;
                nk256 = 1'b1;
                in256 = ~PT0;
            end else begin
                st256 = 1'b0;
            end
            if (fin256 === 1'b1) begin
                fins++;
                if (lat < 0) begin
                    lat = m;
                    got = out256;
                end
            end
            @(negedge clk);
        end
        total += 4;
        if (fins !== 1) begin bad++; $display("FAIL a256_finish_count got %0d want 1", fins); end
        if (lat !== 67) begin bad++; $display("FAIL a256_latency got %0d want 67", lat); end
        if (got !== 128'h8ea2b7ca516745bfeafc49904b496089) begin
            bad++;
            $display("FAIL a256_out got %h want 8ea2b7ca516745bfeafc49904b496089", got);
        end
        if (busy256 !== 1'b0) begin bad++; $display("FAIL a256_idle got %b want 0", busy256); end
    endtask

    initial begin
        test_reset();
        test_fips128();
        test_back_to_back();
        test_reset_mid_expand();
        test_rekey();
        test_aes192();
        test_aes256_ignore_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
